// File: rtl/branch_ctrl.sv
// Branch-resolution controller: NVZ flag register, condition evaluation, flag-hazard stall,
// PC redirect / IF-ID flush and saturating branch counters. Optional macro: FLAG_FWD_EN.
module branch_ctrl #(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_stall,
    input  logic             ex_valid,
    input  logic [2:0]       ex_flag_wr,
    input  logic [2:0]       alu_nvz,
    input  logic             id_valid,
    input  logic             id_is_b,
    input  logic             id_is_br,
    input  logic [2:0]       id_cond,
    input  logic [PC_W-1:0]  id_pc_plus2,
    input  logic [8:0]       id_imm9,
    input  logic [PC_W-1:0]  id_rs_data,
    input  logic             cnt_clr,
    output logic [2:0]       nvz_q,
    output logic             stall_branch,
    output logic             redirect,
    output logic [PC_W-1:0]  target_pc,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e           state_q, state_d;
    logic [2:0]       nvz_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic             br;
    logic             hazard;
    logic             resolve;
    logic             taken;
    logic [2:0]       eval_nvz;
    logic [PC_W-1:0]  b_offset;

    // Flags are {N,V,Z}
    function automatic logic cond_eval(input logic [2:0] c, input logic [2:0] f);
        logic n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        unique case (c)
            3'b000:  cond_eval = !z;
            3'b001:  cond_eval = z;
            3'b010:  cond_eval = !z && !n;
            3'b011:  cond_eval = n;
            3'b100:  cond_eval = z || (!z && !n);
            3'b101:  cond_eval = n || z;
            3'b110:  cond_eval = v;
            default: cond_eval = 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] cond_need(input logic [2:0] c);
        unique case (c)
            3'b000, 3'b001:         cond_need = 3'b001;
            3'b010, 3'b100, 3'b101: cond_need = 3'b101;
            3'b011:                 cond_need = 3'b100;
            3'b110:                 cond_need = 3'b010;
            default:                cond_need = 3'b000;
        endcase
    endfunction

    assign br = id_valid & (id_is_b | id_is_br);

`ifdef FLAG_FWD_EN
    assign hazard   = 1'b0;
    assign eval_nvz = ({3{ex_valid}} & ex_flag_wr & alu_nvz)
                    | (~({3{ex_valid}} & ex_flag_wr) & nvz_q);
`else
    assign hazard   = br & ex_valid & (|(ex_flag_wr & cond_need(id_cond)));
    assign eval_nvz = nvz_q;
`endif

    always_comb begin
        state_d      = state_q;
        stall_branch = 1'b0;
        resolve      = 1'b0;
        if (!pipe_stall) begin
            unique case (state_q)
                StIdle: begin
                    if (hazard) begin
                        stall_branch = 1'b1;
                        state_d      = StHold;
                    end else begin
                        resolve = br;
                    end
                end
                StHold: begin
                    // EX now holds the bubble, so nvz_q already reflects the flag writer
                    resolve = br;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign taken      = cond_eval(id_cond, eval_nvz);
    assign redirect   = resolve & taken;
    assign flush_ifid = resolve & taken;

    assign b_offset  = {{(PC_W - 9){id_imm9[8]}}, id_imm9} << 1;
    assign target_pc = id_is_b ? (id_pc_plus2 + b_offset) : id_rs_data;

    always_comb begin
        nvz_d = nvz_q;
        if (ex_valid && !pipe_stall) begin
            nvz_d = (alu_nvz & ex_flag_wr) | (nvz_q & ~ex_flag_wr);
        end
    end

    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (cnt_clr) begin
            br_cnt_d    = '0;
            taken_cnt_d = '0;
        end else if (resolve) begin
            if (br_cnt_q != '1) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (taken && (taken_cnt_q != '1)) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            nvz_q       <= 3'b000;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            nvz_q       <= nvz_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; expectations follow FLAG_FWD_EN when defined.
module tb_branch_ctrl;

    localparam int unsigned PC_W  = 16;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             pipe_stall;
    logic             ex_valid;
    logic [2:0]       ex_flag_wr;
    logic [2:0]       alu_nvz;
    logic             id_valid;
    logic             id_is_b;
    logic             id_is_br;
    logic [2:0]       id_cond;
    logic [PC_W-1:0]  id_pc_plus2;
    logic [8:0]       id_imm9;
    logic [PC_W-1:0]  id_rs_data;
    logic             cnt_clr;
    logic [2:0]       nvz_q;
    logic             stall_branch;
    logic             redirect;
    logic [PC_W-1:0]  target_pc;
    logic             flush_ifid;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_ctrl #(
        .PC_W (PC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_stall  (pipe_stall),
        .ex_valid    (ex_valid),
        .ex_flag_wr  (ex_flag_wr),
        .alu_nvz     (alu_nvz),
        .id_valid    (id_valid),
        .id_is_b     (id_is_b),
        .id_is_br    (id_is_br),
        .id_cond     (id_cond),
        .id_pc_plus2 (id_pc_plus2),
        .id_imm9     (id_imm9),
        .id_rs_data  (id_rs_data),
        .cnt_clr     (cnt_clr),
        .nvz_q       (nvz_q),
        .stall_branch(stall_branch),
        .redirect    (redirect),
        .target_pc   (target_pc),
        .flush_ifid  (flush_ifid),
        .br_cnt      (br_cnt),
        .taken_cnt   (taken_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        pipe_stall  = 1'b0;
        ex_valid    = 1'b0;
        ex_flag_wr  = 3'b000;
        alu_nvz     = 3'b000;
        id_valid    = 1'b0;
        id_is_b     = 1'b0;
        id_is_br    = 1'b0;
        id_cond     = 3'b000;
        id_pc_plus2 = '0;
        id_imm9     = '0;
        id_rs_data  = '0;
        cnt_clr     = 1'b0;
    endtask

    task automatic set_b(input logic [2:0] c, input logic [15:0] pc2, input logic [8:0] imm);
        id_valid    = 1'b1;
        id_is_b     = 1'b1;
        id_is_br    = 1'b0;
        id_cond     = c;
        id_pc_plus2 = pc2;
        id_imm9     = imm;
    endtask

    task automatic set_ex(input logic [2:0] m, input logic [2:0] f);
        ex_valid   = 1'b1;
        ex_flag_wr = m;
        alu_nvz    = f;
    endtask

    task automatic test_reset();
        idle_in();
        rst = 1'b1;
        set_ex(3'b111, 3'b111);
        tick();
        n_vec++; if (nvz_q !== 3'b000) begin n_err++; $display("FAIL reset_nvz: got %b want 000", nvz_q); end
        n_vec++; if (br_cnt !== 16'h0) begin n_err++; $display("FAIL reset_br_cnt: got %h want 0000", br_cnt); end
        n_vec++; if (taken_cnt !== 16'h0) begin n_err++; $display("FAIL reset_taken_cnt: got %h want 0000", taken_cnt); end
        n_vec++; if (redirect !== 1'b0 || stall_branch !== 1'b0 || flush_ifid !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl: got r=%b s=%b f=%b want 0 0 0", redirect, stall_branch, flush_ifid);
        end
        idle_in();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        set_b(3'b001, 16'h0000, 9'h000);
        #1;
        n_vec++; if (redirect !== 1'b0 || flush_ifid !== 1'b0 || stall_branch !== 1'b0) begin
            n_err++; $display("FAIL basic_ctrl: got r=%b f=%b s=%b want 0 0 0", redirect, flush_ifid, stall_branch);
        end
        tick();
        n_vec++; if (br_cnt !== 16'd1) begin n_err++; $display("FAIL basic_br_cnt: got %0d want 1", br_cnt); end
        n_vec++; if (taken_cnt !== 16'd0) begin n_err++; $display("FAIL basic_taken_cnt: got %0d want 0", taken_cnt); end
        idle_in();
    endtask

    task automatic test_hazard();
        set_ex(3'b111, 3'b001);
        set_b(3'b001, 16'h0040, 9'h1FE);
        #1;
`ifndef FLAG_FWD_EN
        n_vec++; if (stall_branch !== 1'b1 || redirect !== 1'b0 || flush_ifid !== 1'b0) begin
            n_err++; $display("FAIL hazard_c1: got s=%b r=%b f=%b want 1 0 0", stall_branch, redirect, flush_ifid);
        end
        tick();
        ex_valid = 1'b0;
        #1;
`endif
        n_vec++; if (stall_branch !== 1'b0 || redirect !== 1'b1 || flush_ifid !== 1'b1) begin
            n_err++; $display("FAIL hazard_resolve: got s=%b r=%b f=%b want 0 1 1", stall_branch, redirect, flush_ifid);
        end
        n_vec++; if (target_pc !== 16'h003C) begin n_err++; $display("FAIL hazard_target: got %h want 003c", target_pc); end
        tick();
        n_vec++; if (br_cnt !== 16'd2 || taken_cnt !== 16'd1) begin
            n_err++; $display("FAIL hazard_cnt: got %0d/%0d want 2/1", br_cnt, taken_cnt);
        end
        n_vec++; if (nvz_q !== 3'b001) begin n_err++; $display("FAIL hazard_nvz: got %b want 001", nvz_q); end
        idle_in();
    endtask

    task automatic test_br_always();
        set_ex(3'b111, 3'b000);
        id_valid   = 1'b1;
        id_is_br   = 1'b1;
        id_cond    = 3'b111;
        id_rs_data = 16'hBEEF;
        #1;
        n_vec++; if (stall_branch !== 1'b0 || redirect !== 1'b1) begin
            n_err++; $display("FAIL br_always_ctrl: got s=%b r=%b want 0 1", stall_branch, redirect);
        end
        n_vec++; if (target_pc !== 16'hBEEF) begin n_err++; $display("FAIL br_always_target: got %h want beef", target_pc); end
        tick();
        n_vec++; if (nvz_q !== 3'b000 || br_cnt !== 16'd3 || taken_cnt !== 16'd2) begin
            n_err++; $display("FAIL br_always_state: got nvz=%b %0d/%0d want 000 3/2", nvz_q, br_cnt, taken_cnt);
        end
        idle_in();
    endtask

    task automatic test_cond_v();
        set_ex(3'b010, 3'b010);
        #1;
        n_vec++; if (redirect !== 1'b0 || stall_branch !== 1'b0 || flush_ifid !== 1'b0) begin
            n_err++; $display("FAIL nonbranch_ctrl: got r=%b s=%b f=%b want 0 0 0", redirect, stall_branch, flush_ifid);
        end
        tick();
        n_vec++; if (nvz_q !== 3'b010) begin n_err++; $display("FAIL v_set_nvz: got %b want 010", nvz_q); end
        set_ex(3'b001, 3'b001);
        set_b(3'b110, 16'h0100, 9'h005);
        #1;
        n_vec++; if (stall_branch !== 1'b0 || redirect !== 1'b1 || target_pc !== 16'h010A) begin
            n_err++; $display("FAIL v_taken: got s=%b r=%b t=%h want 0 1 010a", stall_branch, redirect, target_pc);
        end
        tick();
        n_vec++; if (nvz_q !== 3'b011) begin n_err++; $display("FAIL v_z_write: got %b want 011", nvz_q); end
        idle_in();
        set_ex(3'b010, 3'b000);
        tick();
        idle_in();
        set_b(3'b110, 16'h0100, 9'h005);
        #1;
        n_vec++; if (redirect !== 1'b0 || flush_ifid !== 1'b0) begin
            n_err++; $display("FAIL v_not_taken: got r=%b f=%b want 0 0", redirect, flush_ifid);
        end
        tick();
        n_vec++; if (br_cnt !== 16'd5 || taken_cnt !== 16'd3 || nvz_q !== 3'b001) begin
            n_err++; $display("FAIL v_state: got %0d/%0d nvz=%b want 5/3 001", br_cnt, taken_cnt, nvz_q);
        end
        idle_in();
    endtask

    task automatic test_conds();
        // With N=0 V=0 Z=1, bit c gives whether condition c is taken
        logic [7:0] tbl;
        tbl = 8'b1011_0010;
        for (int c = 0; c < 8; c++) begin
            set_b(3'(c), 16'h0200, 9'h000);
            #1;
            n_vec++; if (redirect !== tbl[c]) begin
                n_err++; $display("FAIL cond_%0d: got %b want %b", c, redirect, tbl[c]);
            end
            tick();
        end
        n_vec++; if (br_cnt !== 16'd13 || taken_cnt !== 16'd7) begin
            n_err++; $display("FAIL conds_cnt: got %0d/%0d want 13/7", br_cnt, taken_cnt);
        end
        idle_in();
    endtask

    task automatic test_b_priority();
        set_b(3'b111, 16'h0010, 9'h0FF);
        id_is_br   = 1'b1;
        id_rs_data = 16'hBEEF;
        #1;
        n_vec++; if (redirect !== 1'b1 || target_pc !== 16'h020E) begin
            n_err++; $display("FAIL b_priority: got r=%b t=%h want 1 020e", redirect, target_pc);
        end
        tick();
        idle_in();
    endtask

    task automatic test_pipe_stall();
        set_b(3'b111, 16'h0300, 9'h010);
        set_ex(3'b111, 3'b110);
        pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (redirect !== 1'b0 || flush_ifid !== 1'b0 || stall_branch !== 1'b0) begin
                n_err++; $display("FAIL stall_ctrl_%0d: got r=%b f=%b s=%b want 0 0 0", i, redirect, flush_ifid, stall_branch);
            end
            tick();
            n_vec++; if (br_cnt !== 16'd14 || taken_cnt !== 16'd8 || nvz_q !== 3'b001) begin
                n_err++; $display("FAIL stall_hold_%0d: got %0d/%0d nvz=%b want 14/8 001", i, br_cnt, taken_cnt, nvz_q);
            end
        end
        pipe_stall = 1'b0;
        ex_valid   = 1'b0;
        #1;
        n_vec++; if (redirect !== 1'b1 || target_pc !== 16'h0320) begin
            n_err++; $display("FAIL stall_release: got r=%b t=%h want 1 0320", redirect, target_pc);
        end
        tick();
        idle_in();
        tick();
        n_vec++; if (br_cnt !== 16'd15 || taken_cnt !== 16'd9) begin
            n_err++; $display("FAIL stall_cnt: got %0d/%0d want 15/9", br_cnt, taken_cnt);
        end
    endtask

    task automatic test_reset_hold();
        set_ex(3'b101, 3'b100);
        set_b(3'b000, 16'h0000, 9'h000);
        #1;
`ifndef FLAG_FWD_EN
        n_vec++; if (stall_branch !== 1'b1) begin n_err++; $display("FAIL rsthold_stall: got %b want 1", stall_branch); end
`endif
        tick();
        n_vec++; if (nvz_q !== 3'b100) begin n_err++; $display("FAIL rsthold_nvz: got %b want 100", nvz_q); end
        rst = 1'b1;
        #1;
        n_vec++; if (nvz_q !== 3'b000 || br_cnt !== 16'd0 || taken_cnt !== 16'd0) begin
            n_err++; $display("FAIL rsthold_async: got nvz=%b %0d/%0d want 000 0/0", nvz_q, br_cnt, taken_cnt);
        end
        rst = 1'b0;
        #1;
`ifndef FLAG_FWD_EN
        n_vec++; if (stall_branch !== 1'b1 || redirect !== 1'b0) begin
            n_err++; $display("FAIL rsthold_idle: got s=%b r=%b want 1 0", stall_branch, redirect);
        end
`else
        n_vec++; if (stall_branch !== 1'b0 || redirect !== 1'b1) begin
            n_err++; $display("FAIL rsthold_idle: got s=%b r=%b want 0 1", stall_branch, redirect);
        end
`endif
        idle_in();
        tick();
    endtask

    task automatic test_cnt_clr();
        set_b(3'b111, 16'h0000, 9'h000);
        tick();
        tick();
        cnt_clr = 1'b1;
        tick();
        n_vec++; if (br_cnt !== 16'd0 || taken_cnt !== 16'd0) begin
            n_err++; $display("FAIL clr_priority: got %0d/%0d want 0/0", br_cnt, taken_cnt);
        end
        cnt_clr = 1'b0;
        tick();
        n_vec++; if (br_cnt !== 16'd1 || taken_cnt !== 16'd1) begin
            n_err++; $display("FAIL clr_count: got %0d/%0d want 1/1", br_cnt, taken_cnt);
        end
        idle_in();
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        set_b(3'b111, 16'h0000, 9'h000);
        repeat (16'hFFFE) tick();
        n_vec++; if (br_cnt !== 16'hFFFE || taken_cnt !== 16'hFFFE) begin
            n_err++; $display("FAIL sat_preload: got %h/%h want fffe/fffe", br_cnt, taken_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (br_cnt !== 16'hFFFF || taken_cnt !== 16'hFFFF) begin
                n_err++; $display("FAIL sat_%0d: got %h/%h want ffff/ffff", i, br_cnt, taken_cnt);
            end
        end
        cnt_clr = 1'b1;
        tick();
        n_vec++; if (br_cnt !== 16'h0 || taken_cnt !== 16'h0) begin
            n_err++; $display("FAIL sat_clr: got %h/%h want 0000/0000", br_cnt, taken_cnt);
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hazard();
        test_br_always();
        test_cond_v();
        test_conds();
        test_b_priority();
        test_pipe_stall();
        test_reset_hold();
        test_cnt_clr();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
